// File: rtl/neopixel_driver.sv
// WS2812 (NeoPixel) responder: buffers per-pixel colour bytes written by a controller
// and serialises the whole frame, GRB MSB-first, followed by a low latch period.
module neopixel_driver #(
    parameter int unsigned NUM_PIXELS   = 5,
    parameter int unsigned T0H          = 18,
    parameter int unsigned T0L          = 45,
    parameter int unsigned T1H          = 35,
    parameter int unsigned T1L          = 28,
    parameter int unsigned RESET_CYCLES = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_color,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       send_it,
    output logic       neo_data,
    output logic       ready_to_load,
    output logic       ready_to_send
);
    localparam int unsigned MAX_H  = (T0H > T1H) ? T0H : T1H;
    localparam int unsigned MAX_L  = (T0L > T1L) ? T0L : T1L;
    localparam int unsigned MAX_B  = (MAX_H > MAX_L) ? MAX_H : MAX_L;
    localparam int unsigned MAX_T  = (MAX_B > RESET_CYCLES) ? MAX_B : RESET_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_T + 1);
    localparam int unsigned PIX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int unsigned BIT_W  = 5;
    localparam int unsigned WORD_W = 24;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [WORD_W-1:0]   frame_q [NUM_PIXELS];
    logic [WORD_W-1:0]   frame_d [NUM_PIXELS];
    logic                neo_q, neo_d;
    logic                ready_q, ready_d;
    logic                load_ok;
    logic [WORD_W-1:0]   next_word;
    logic [CNT_W-1:0]    high_last;
    logic [CNT_W-1:0]    low_last;

    // Frame buffer write; each pixel word is stored in wire order {G, R, B}.
    always_comb begin
        frame_d = frame_q;
        load_ok = (state_q == IDLE) && load_color && (color_index != 2'd3);
        for (int unsigned p = 0; p < NUM_PIXELS; p++) begin
            if (load_ok && (pixel_index == 3'(p))) begin
                case (color_index)
                    2'd0:    frame_d[p][15:8]  = color_level;
                    2'd1:    frame_d[p][23:16] = color_level;
                    2'd2:    frame_d[p][7:0]   = color_level;
                    default: frame_d[p]        = frame_q[p];
                endcase
            end
        end
    end

    // Word of the pixel after the current one, and per-bit phase lengths.
    always_comb begin
        next_word = '0;
        for (int unsigned p = 1; p < NUM_PIXELS; p++) begin
            if (pix_q == PIX_W'(p - 1)) begin
                next_word = frame_q[p];
            end
        end
        high_last = shift_q[WORD_W-1] ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
        low_last  = shift_q[WORD_W-1] ? CNT_W'(T1L - 1) : CNT_W'(T0L - 1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        shift_d = shift_q;
        neo_d   = neo_q;

        case (state_q)
            IDLE: begin
                // frame_d already holds a same-cycle write, so it is included in pixel 0.
                if (send_it) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    bit_d   = '0;
                    pix_d   = '0;
                    shift_d = frame_d[0];
                    neo_d   = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == high_last) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    neo_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt_q == low_last) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(WORD_W - 1)) begin
                        if (pix_q == PIX_W'(NUM_PIXELS - 1)) begin
                            state_d = LATCH;
                            neo_d   = 1'b0;
                        end else begin
                            state_d = HIGH;
                            pix_d   = pix_q + PIX_W'(1);
                            bit_d   = '0;
                            shift_d = next_word;
                            neo_d   = 1'b1;
                        end
                    end else begin
                        state_d = HIGH;
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {shift_q[WORD_W-2:0], 1'b0};
                        neo_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LATCH: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                neo_d   = 1'b0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            shift_q <= '0;
            frame_q <= '{default: '0};
            neo_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            shift_q <= shift_d;
            frame_q <= frame_d;
            neo_q   <= neo_d;
            ready_q <= ready_d;
        end
    end

    assign neo_data      = neo_q;
    assign ready_to_load = ready_q;
    assign ready_to_send = ready_q;

endmodule

// File: tb/tb_neopixel_driver.sv
// Bench for neopixel_driver: table-driven frames, random loads against a frame model,
// and hand sequences for mid-frame pokes and reset abort.
module tb_neopixel_driver;
    localparam int unsigned NP     = 2;
    localparam int unsigned T0H    = 2;
    localparam int unsigned T0L    = 4;
    localparam int unsigned T1H    = 4;
    localparam int unsigned T1L    = 2;
    localparam int unsigned RC     = 10;
    localparam int unsigned NB     = NP * 24;
    localparam int unsigned FRAME  = NB * (T0H + T0L) + RC;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_color;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       send_it;
    logic       neo_data;
    logic       ready_to_load;
    logic       ready_to_send;

    int errors = 0;
    int checks = 0;
    logic [7:0] mdl [NP][3];

    neopixel_driver #(
        .NUM_PIXELS(NP), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .RESET_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset), .load_color(load_color), .pixel_index(pixel_index),
        .color_index(color_index), .color_level(color_level), .send_it(send_it),
        .neo_data(neo_data), .ready_to_load(ready_to_load), .ready_to_send(ready_to_send)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          ld;
        bit          send;
        bit          same;
        int          p;
        int          c;
        logic [7:0]  lvl;
        int          poke;
        logic [NB-1:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void mdl_clear();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                mdl[p][c] = 8'h00;
    endfunction

    function automatic void mdl_write(input int p, input int c, input logic [7:0] v);
        if (p < NP && c < 3) mdl[p][c] = v;
    endfunction

    // Frame bits in transmission order: pixel 0 first, G then R then B, MSB first.
    function automatic logic [NB-1:0] mdl_bits();
        logic [NB-1:0] r;
        int idx;
        int order [3];
        order = '{1, 0, 2};
        r = '0;
        idx = NB - 1;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 3; k++)
                for (int b = 7; b >= 0; b--) begin
                    r[idx] = mdl[p][order[k]][b];
                    idx--;
                end
        return r;
    endfunction

    task automatic load_one(input int p, input int c, input logic [7:0] v);
        load_color  = 1'b1;
        pixel_index = 3'(p);
        color_index = 2'(c);
        color_level = v;
        mdl_write(p, c, v);
        tick();
        load_color = 1'b0;
    endtask

    // Send a frame (optionally with a same-cycle load), capture and check it.
    task automatic do_frame(input string tag, input bit ld, input int p, input int c,
                            input logic [7:0] lvl, input int poke_at, input int reset_at,
                            output logic [NB-1:0] got);
        bit wave [$];
        bit samp [$];
        logic [NB-1:0] exp;
        int wave_err, rdy_err, run, nb, bad_pulse, post_bad;
        bit exp_neo, exp_rdy;

        if (ld) mdl_write(p, c, lvl);
        exp = mdl_bits();
        for (int i = NB - 1; i >= 0; i--) begin
            for (int h = 0; h < int'(exp[i] ? T1H : T0H); h++) wave.push_back(1'b1);
            for (int l = 0; l < int'(exp[i] ? T1L : T0L); l++) wave.push_back(1'b0);
        end

        load_color  = ld;
        pixel_index = 3'(p);
        color_index = 2'(c);
        color_level = lvl;
        send_it     = 1'b1;
        tick();
        load_color = 1'b0;
        send_it    = 1'b0;

        wave_err = 0;
        rdy_err  = 0;
        got      = '0;
        for (int k = 0; k <= int'(FRAME); k++) begin
            exp_neo = (k < wave.size()) ? wave[k] : 1'b0;
            exp_rdy = (k >= int'(FRAME));
            samp.push_back(neo_data);
            if (neo_data !== exp_neo) wave_err++;
            if (ready_to_load !== exp_rdy || ready_to_send !== exp_rdy) rdy_err++;
            if (k == reset_at) begin
                #2 reset = 1'b1;
                #1;
                check({tag, "_rst_neo"}, 64'(neo_data), 64'd0);
                check({tag, "_rst_ready"}, 64'({ready_to_load, ready_to_send}), 64'b11);
                mdl_clear();
                tick();
                check({tag, "_rst_hold_neo"}, 64'(neo_data), 64'd0);
                reset = 1'b0;
                tick();
                check({tag, "_post_rst_ready"}, 64'({ready_to_load, ready_to_send}), 64'b11);
                check({tag, "_pre_rst_wave"}, 64'(wave_err), 64'd0);
                return;
            end
            if (k < int'(FRAME)) begin
                if (k == poke_at) begin
                    load_color  = 1'b1;
                    pixel_index = 3'd0;
                    color_index = 2'd0;
                    color_level = 8'h55;
                    send_it     = 1'b1;
                end else begin
                    load_color = 1'b0;
                    send_it    = 1'b0;
                end
                tick();
            end
        end
        load_color = 1'b0;
        send_it    = 1'b0;

        run = 0;
        nb = 0;
        bad_pulse = 0;
        foreach (samp[i]) begin
            if (samp[i]) run++;
            else if (run > 0) begin
                if (run == int'(T1H)) got = {got[NB-2:0], 1'b1};
                else if (run == int'(T0H)) got = {got[NB-2:0], 1'b0};
                else bad_pulse++;
                nb++;
                run = 0;
            end
        end

        post_bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (neo_data !== 1'b0 || ready_to_send !== 1'b1) post_bad++;
        end

        check({tag, "_wave"}, 64'(wave_err), 64'd0);
        check({tag, "_ready_timing"}, 64'(rdy_err), 64'd0);
        check({tag, "_bit_count"}, 64'(nb), 64'(NB));
        check({tag, "_pulse_width"}, 64'(bad_pulse), 64'd0);
        check({tag, "_bits_model"}, 64'(got), 64'(exp));
        check({tag, "_post_idle"}, 64'(post_bad), 64'd0);
    endtask

    initial begin
        logic [NB-1:0] got;
        int bad_neo, bad_rdy;

        reset       = 1'b1;
        load_color  = 1'b0;
        pixel_index = '0;
        color_index = '0;
        color_level = '0;
        send_it     = 1'b0;
        mdl_clear();
        #3;
        check("reset_neo", 64'(neo_data), 64'd0);
        check("reset_ready_load", 64'(ready_to_load), 64'd1);
        check("reset_ready_send", 64'(ready_to_send), 64'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        bad_neo = 0;
        bad_rdy = 0;
        for (int k = 0; k < 300; k++) begin
            if (neo_data !== 1'b0) bad_neo++;
            if (ready_to_load !== 1'b1 || ready_to_send !== 1'b1) bad_rdy++;
            tick();
        end
        check("idle_neo", 64'(bad_neo), 64'd0);
        check("idle_ready", 64'(bad_rdy), 64'd0);

        tbl[0] = '{ld: 0, send: 1, same: 0, p: 0, c: 0, lvl: 8'h00, poke: -1, exp: 48'h000000_000000};
        tbl[1] = '{ld: 1, send: 0, same: 0, p: 0, c: 0, lvl: 8'h80, poke: -1, exp: 48'h0};
        tbl[2] = '{ld: 1, send: 0, same: 0, p: 0, c: 1, lvl: 8'h01, poke: -1, exp: 48'h0};
        tbl[3] = '{ld: 1, send: 1, same: 0, p: 0, c: 2, lvl: 8'h00, poke: -1, exp: 48'h018000_000000};
        tbl[4] = '{ld: 1, send: 1, same: 1, p: 1, c: 2, lvl: 8'hFF, poke: -1, exp: 48'h018000_0000FF};
        tbl[5] = '{ld: 0, send: 1, same: 0, p: 0, c: 0, lvl: 8'h00, poke: 50, exp: 48'h018000_0000FF};
        tbl[6] = '{ld: 0, send: 1, same: 0, p: 0, c: 0, lvl: 8'h00, poke: -1, exp: 48'h018000_0000FF};
        tbl[7] = '{ld: 1, send: 1, same: 0, p: 5, c: 0, lvl: 8'hAA, poke: -1, exp: 48'h018000_0000FF};
        tbl[8] = '{ld: 1, send: 1, same: 1, p: 0, c: 3, lvl: 8'hAA, poke: -1, exp: 48'h018000_0000FF};
        tbl[9] = '{ld: 1, send: 1, same: 1, p: 1, c: 0, lvl: 8'h3C, poke: -1, exp: 48'h018000_003CFF};

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].ld && !tbl[i].same) load_one(tbl[i].p, tbl[i].c, tbl[i].lvl);
            if (tbl[i].send) begin
                do_frame($sformatf("vec%0d", i), tbl[i].ld && tbl[i].same, tbl[i].p, tbl[i].c,
                         tbl[i].lvl, tbl[i].poke, -1, got);
                check($sformatf("vec%0d_bits_table", i), 64'(got), 64'(tbl[i].exp));
            end
        end

        for (int f = 0; f < 6; f++) begin
            int nld;
            nld = int'($urandom_range(0, 4));
            for (int j = 0; j < nld; j++)
                load_one(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 8'($urandom));
            do_frame($sformatf("rnd%0d", f), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)), 8'($urandom), -1, -1, got);
        end

        load_one(0, 1, 8'hFF);
        load_one(1, 0, 8'hA5);
        do_frame("abort", 1'b0, 0, 0, 8'h00, -1, 100, got);
        do_frame("after_rst", 1'b0, 0, 0, 8'h00, -1, -1, got);
        check("after_rst_all_zero", 64'(got), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
